// File: rtl/cu_sequencer.sv
// Step sequencer for the multi-cycle CPU control unit: a fixed fetch run, then a per-opcode
// execute window, with stall hold, interrupt entry and halt taken only at instruction boundaries.
module cu_sequencer #(
    parameter int N           = 6,
    parameter int STATES      = 40,
    parameter int OPW         = 4,
    parameter int FETCH_STEPS = 3,
    parameter int OP_STEPS    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [OPW-1:0]    opcode,
    input  logic              stall,
    input  logic              instr_done,
    input  logic              irq,
    input  logic              halt_req,
    input  logic              resume,
    output logic [N-1:0]      counter_value,
    output logic [STATES-1:0] cpu_state,
    output logic [OPW-1:0]    opcode_q,
    output logic              fetch,
    output logic              irq_ack,
    output logic              halted
);

    generate
        if (FETCH_STEPS + (2**OPW) * OP_STEPS > STATES - 2) begin : g_chk_steps
            $error("cu_sequencer: execute windows overlap the IRQ/HALTED steps");
        end
        if ((2**N) < STATES) begin : g_chk_width
            $error("cu_sequencer: counter width too small for STATES");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_IRQ    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [N-1:0] FETCH_LAST = N'(FETCH_STEPS - 1);
    localparam logic [N-1:0] IRQ_STEP   = N'(STATES - 2);
    localparam logic [N-1:0] HALT_STEP  = N'(STATES - 1);

    state_t         state_reg, state_next;
    logic [N-1:0]   counter_reg, counter_next;
    logic [OPW-1:0] opcode_reg, opcode_next;
    state_t         bnd_state;
    logic [N-1:0]   bnd_counter;
    logic [N-1:0]   fetch_base;
    logic [N-1:0]   exec_last;

    // Base of the execute window for the incoming opcode and last step of the latched one.
    assign fetch_base = N'(FETCH_STEPS) + N'(opcode) * N'(OP_STEPS);
    assign exec_last  = N'(FETCH_STEPS) + N'(opcode_reg) * N'(OP_STEPS) + N'(OP_STEPS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            opcode_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            opcode_reg  <= opcode_next;
        end
    end

    // Destination when an instruction boundary is taken; halt outranks interrupt.
    always_comb begin
        bnd_state   = S_IDLE;
        bnd_counter = '0;
        if (halt_req) begin
            bnd_state   = S_HALTED;
            bnd_counter = HALT_STEP;
        end else if (irq) begin
            bnd_state   = S_IRQ;
            bnd_counter = IRQ_STEP;
        end else if (en) begin
            bnd_state   = S_FETCH;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        opcode_next  = opcode_reg;
        case (state_reg)
            S_IDLE: begin
                counter_next = '0;
                if (en) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (!stall) begin
                    if (counter_reg == FETCH_LAST) begin
                        opcode_next  = opcode;
                        counter_next = fetch_base;
                        state_next   = S_EXEC;
                    end else begin
                        counter_next = counter_reg + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (instr_done || counter_reg == exec_last) begin
                        state_next   = bnd_state;
                        counter_next = bnd_counter;
                    end else begin
                        counter_next = counter_reg + 1'b1;
                    end
                end
            end
            S_IRQ: begin
                state_next   = S_FETCH;
                counter_next = '0;
            end
            S_HALTED: begin
                counter_next = HALT_STEP;
                if (resume) begin
                    state_next   = S_FETCH;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = S_IDLE;
                counter_next = '0;
            end
        endcase
    end

    always_comb begin
        fetch   = (state_reg == S_FETCH);
        irq_ack = (state_reg == S_IRQ);
        halted  = (state_reg == S_HALTED);
    end

    assign counter_value = counter_reg;
    assign opcode_q      = opcode_reg;

    generate
        for (genvar gi = 0; gi < STATES; gi++) begin : g_onehot
            assign cpu_state[gi] = (counter_reg == N'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed-step bench for cu_sequencer with hand-computed expected counter sequences.
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  opcode = '0;
    logic        stall = 1'b0;
    logic        instr_done = 1'b0;
    logic        irq = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [5:0]  counter_value;
    logic [39:0] cpu_state;
    logic [3:0]  opcode_q;
    logic        fetch;
    logic        irq_ack;
    logic        halted;

    int checks = 0;
    int errors = 0;

    cu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .stall(stall),
        .instr_done(instr_done), .irq(irq), .halt_req(halt_req), .resume(resume),
        .counter_value(counter_value), .cpu_state(cpu_state), .opcode_q(opcode_q),
        .fetch(fetch), .irq_ack(irq_ack), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks counter, its one-hot image and the three status outputs.
    task automatic expect_cnt(input string tag, input int cnt, input logic f,
                              input logic ack, input logic h);
        logic [39:0] one;
        one = 40'd1 << cnt;
        $display("%s: counter=%0d fetch=%0b irq_ack=%0b halted=%0b opcode_q=%0d",
                 tag, counter_value, fetch, irq_ack, halted, opcode_q);
        chk({tag, ".counter"}, 64'(counter_value), 64'(cnt));
        chk({tag, ".cpu_state"}, 64'(cpu_state), 64'(one));
        chk({tag, ".fetch"}, 64'(fetch), 64'(f));
        chk({tag, ".irq_ack"}, 64'(irq_ack), 64'(ack));
        chk({tag, ".halted"}, 64'(halted), 64'(h));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        expect_cnt("reset", 0, 1'b0, 1'b0, 1'b0);
        chk("reset.opcode_q", 64'(opcode_q), 64'd0);

        // Basic sequence, opcode 4 -> window 11..12
        en = 1'b1; opcode = 4'd4;
        #2 rst_n = 1'b1;
        step; expect_cnt("basic.f0", 0, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("basic.f1", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("basic.f2", 2, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("basic.e11", 11, 1'b0, 1'b0, 1'b0);
        chk("basic.opcode_q", 64'(opcode_q), 64'd4);
        step; expect_cnt("basic.e12", 12, 1'b0, 1'b0, 1'b0);
        step; expect_cnt("basic.next", 0, 1'b1, 1'b0, 1'b0);

        // Opcode 15 -> window 33..34; stall masks instr_done, then early end
        opcode = 4'd15;
        step; expect_cnt("early.f1", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("early.f2", 2, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("early.e33", 33, 1'b0, 1'b0, 1'b0);
        chk("early.opcode_q", 64'(opcode_q), 64'd15);
        stall = 1'b1; instr_done = 1'b1;
        step; expect_cnt("early.stall_done", 33, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        step; expect_cnt("early.done", 0, 1'b1, 1'b0, 1'b0);
        instr_done = 1'b0;

        // Stall during fetch
        opcode = 4'd4;
        step; expect_cnt("fstall.f1", 1, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        step; expect_cnt("fstall.h1", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("fstall.h2", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("fstall.h3", 1, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step; expect_cnt("fstall.f2", 2, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("fstall.e11", 11, 1'b0, 1'b0, 1'b0);

        // Interrupt entry at the boundary after step 12; IRQ exits to FETCH even with en=0
        step; expect_cnt("irq.e12", 12, 1'b0, 1'b0, 1'b0);
        irq = 1'b1;
        step; expect_cnt("irq.entry", 38, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        step; expect_cnt("irq.exit", 0, 1'b1, 1'b0, 1'b0);
        irq = 1'b0; en = 1'b1;

        // Halt outranks interrupt; halted ignores halt_req/irq until resume
        step; expect_cnt("halt.f1", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("halt.f2", 2, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("halt.e11", 11, 1'b0, 1'b0, 1'b0);
        step; expect_cnt("halt.e12", 12, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b1; irq = 1'b1;
        step; expect_cnt("halt.entry", 39, 1'b0, 1'b0, 1'b1);
        step; expect_cnt("halt.hold", 39, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b0; irq = 1'b0; resume = 1'b1;
        step; expect_cnt("halt.resume", 0, 1'b1, 1'b0, 1'b0);
        resume = 1'b0;

        // Asynchronous reset mid-EXEC at step 12
        step; expect_cnt("arst.f1", 1, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("arst.f2", 2, 1'b1, 1'b0, 1'b0);
        step; expect_cnt("arst.e11", 11, 1'b0, 1'b0, 1'b0);
        step; expect_cnt("arst.e12", 12, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_cnt("arst.immediate", 0, 1'b0, 1'b0, 1'b0);
        chk("arst.opcode_q", 64'(opcode_q), 64'd0);
        en = 1'b0;
        #2 rst_n = 1'b1;
        step; expect_cnt("arst.idle1", 0, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        step; expect_cnt("arst.idle2", 0, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
Control-unit step sequencer for the multi-cycle CPU. It generates the step counter that the CU decoder turns into one-hot CPU states, and also outputs that one-hot vector directly. It runs a fixed fetch sequence, jumps to a per-opcode execute window, and handles stalls, interrupt entry and halt at instruction boundaries.

Parameters:
N, 6, counter width; 2**N >= STATES.
STATES, 40, number of CPU states (one-hot width).
OPW, 4, opcode width.
FETCH_STEPS, 3, fetch steps, counter values 0..FETCH_STEPS-1.
OP_STEPS, 2, execute steps allotted per opcode.
- Elaboration check: FETCH_STEPS + 2**OPW*OP_STEPS <= STATES-2.
- Elaboration check: 2**N >= STATES.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  run enable; sampled in IDLE and at instruction boundaries.
opcode  in  OPW  opcode from the instruction register; sampled on the last fetch step.
stall  in  1  holds the sequencer in FETCH or EXEC (memory not ready).
instr_done  in  1  early end of the current instruction; valid in EXEC only.
irq  in  1  level interrupt request.
halt_req  in  1  halt request.
resume  in  1  leave HALTED.
counter_value  out  N  current step; this is the CU decoder input.
cpu_state  out  STATES  one-hot, equal to 1<<counter_value.
opcode_q  out  OPW  opcode latched for the current instruction.
fetch  out  1  high while in FETCH.
irq_ack  out  1  one-cycle pulse on interrupt entry.
halted  out  1  high while in HALTED.

Behaviour:
- FSM states: IDLE, FETCH, EXEC, IRQ, HALTED. All are registered; counter_value is registered. cpu_state is combinational from counter_value.
- Reset (async, immediate, including mid-instruction):
  - state=IDLE, counter=0, cpu_state=1, opcode_q=0.
  - fetch=0, irq_ack=0, halted=0.
- IDLE:
  - Counter is held at 0.
  - en=1 → FETCH next cycle with counter=0.
- FETCH:
  - Each cycle with stall=0, counter increments by 1.
  - At counter=FETCH_STEPS-1 with stall=0: opcode_q<=opcode, counter<=FETCH_STEPS+opcode*OP_STEPS (base), state<=EXEC.
  - Width rule: compute base at N bits; it never overflows because of the elaboration checks.
- EXEC:
  - Each cycle with stall=0, counter increments by 1.
  - Boundary occurs when stall=0 and either instr_done=1 or counter==base+OP_STEPS-1.
- At a boundary, priority order:
  1. halt_req=1 → HALTED, counter=STATES-1.
  2. irq=1 → IRQ, counter=STATES-2.
  3. en=1 → FETCH, counter=0.
  4. Otherwise → IDLE, counter=0.
- stall=1 in FETCH or EXEC:
  - state, counter and opcode_q hold.
  - No boundary is taken, even if instr_done=1.
  - stall is ignored in IDLE, IRQ and HALTED.
- IRQ:
  - Lasts exactly one cycle at counter=STATES-2, with irq_ack=1 in that cycle.
  - Next cycle → FETCH, counter=0, regardless of en.
  - irq is not re-sampled until the next boundary.
- HALTED:
  - counter=STATES-1, halted=1.
  - Exit only via resume=1 (→ FETCH, counter=0) or reset.
  - halt_req and irq are ignored while halted.
- irq and halt_req are sampled only at boundaries. A pulse that falls between boundaries is lost, so requesters hold the signal until acknowledged.
- counter_value is never >= STATES. cpu_state always has exactly one bit set.
- fetch and halted decode from the state register. irq_ack decodes from state==IRQ.

Test Plan:
- Basic sequence:
  - Stimulus: release reset, en=1, opcode=4, no stall, instr_done=0.
  - Response: counter 0,0,1,2,11,12,0; opcode_q=4; cpu_state=1<<counter on every cycle.
- Early end of instruction:
  - Stimulus: opcode=15, instr_done=1 while counter=33.
  - Response: next counter=0; step 34 is skipped.
- Stall during fetch:
  - Stimulus: stall=1 for 3 cycles at counter=1.
  - Response: counter holds at 1 for 3 cycles, then 2, then base.
  - Stimulus: stall=1 together with instr_done=1.
  - Response: no boundary is taken.
- Interrupt entry:
  - Stimulus: irq=1 at a boundary, en=1.
  - Response: counter=38 with irq_ack=1 for exactly one cycle; then counter=0 with fetch=1.
- Halt versus interrupt priority:
  - Stimulus: halt_req=1 and irq=1 at the same boundary.
  - Response: counter=39, halted=1, irq_ack stays 0.
  - Stimulus: resume=1.
  - Response: next counter=0.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst_n=0 mid-EXEC at counter=12.
  - Response: counter=0 and cpu_state=1 immediately, without waiting for a clock edge.
  - Stimulus: release reset with en=0.
  - Response: remains in IDLE.
